// File: rtl/mem_loader.sv
// Byte-stream memory loader: SYNC/CMD framed block writes into memory, then release of the CPU reset.
// Optional checksum byte after each LOAD frame when LOADER_CHKSUM_EN is defined.
module mem_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter logic [7:0] CMD_LOAD  = 8'h01,
    parameter logic [7:0] CMD_RUN   = 8'h02
) (
    input  logic        CLK,
    input  logic        R,
    input  logic [7:0]  IN_DATA,
    input  logic        IN_VALID,
    output logic        IN_READY,
    output logic        MEM_WE,
    output logic [15:0] MEM_ADDR,
    output logic [7:0]  MEM_DATA,
    output logic        CPU_R,
    output logic        ERR
);

    typedef enum logic [7:0] {
        ST_SYNC    = 8'b0000_0001,
        ST_CMD     = 8'b0000_0010,
        ST_ADDR_LO = 8'b0000_0100,
        ST_ADDR_HI = 8'b0000_1000,
        ST_LEN     = 8'b0001_0000,
        ST_DATA    = 8'b0010_0000,
        ST_CHK     = 8'b0100_0000,
        ST_RUN     = 8'b1000_0000
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] ptr, ptr_nxt;
    logic [8:0]  cnt, cnt_nxt;      // bytes left in frame; 9 bits so LEN=0 can mean 256
    logic        err, err_nxt;
    logic        accept;
    logic        wr_p0;

    logic        vld_p1;
    logic [15:0] addr_p1;
    logic [7:0]  data_p1;

`ifdef LOADER_CHKSUM_EN
    logic [7:0] sum, sum_nxt;

    function automatic logic [7:0] add8(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction
`endif

    assign IN_READY = R && (state != ST_RUN);
    assign accept   = IN_VALID && IN_READY;
    assign wr_p0    = accept && (state == ST_DATA);

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        err_nxt   = err;
`ifdef LOADER_CHKSUM_EN
        sum_nxt   = sum;
`endif
        case (state)
            ST_SYNC: begin
                if (accept && IN_DATA == SYNC_BYTE) state_nxt = ST_CMD;
            end
            ST_CMD: begin
                if (accept) begin
                    if (IN_DATA == CMD_LOAD) begin
                        state_nxt = ST_ADDR_LO;
                    end else if (IN_DATA == CMD_RUN) begin
                        state_nxt = ST_RUN;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_SYNC;
                    end
                end
            end
            ST_ADDR_LO: begin
                if (accept) begin
                    ptr_nxt   = {ptr[15:8], IN_DATA};
                    state_nxt = ST_ADDR_HI;
`ifdef LOADER_CHKSUM_EN
                    sum_nxt   = IN_DATA;
`endif
                end
            end
            ST_ADDR_HI: begin
                if (accept) begin
                    ptr_nxt   = {IN_DATA, ptr[7:0]};
                    state_nxt = ST_LEN;
`ifdef LOADER_CHKSUM_EN
                    sum_nxt   = add8(sum, IN_DATA);
`endif
                end
            end
            ST_LEN: begin
                if (accept) begin
                    cnt_nxt   = (IN_DATA == 8'h00) ? 9'd256 : {1'b0, IN_DATA};
                    state_nxt = ST_DATA;
`ifdef LOADER_CHKSUM_EN
                    sum_nxt   = add8(sum, IN_DATA);
`endif
                end
            end
            ST_DATA: begin
                if (accept) begin
                    ptr_nxt = ptr + 16'd1;
                    cnt_nxt = cnt - 9'd1;
`ifdef LOADER_CHKSUM_EN
                    sum_nxt = add8(sum, IN_DATA);
                    if (cnt == 9'd1) state_nxt = ST_CHK;
`else
                    if (cnt == 9'd1) state_nxt = ST_SYNC;
`endif
                end
            end
            ST_CHK: begin
`ifdef LOADER_CHKSUM_EN
                if (accept) begin
                    if (add8(sum, IN_DATA) != 8'h00) err_nxt = 1'b1;
                    state_nxt = ST_SYNC;
                end
`else
                state_nxt = ST_SYNC;
`endif
            end
            ST_RUN: begin
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_SYNC;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!R) begin
            state <= ST_SYNC;
            ptr   <= 16'h0000;
            cnt   <= 9'd0;
            err   <= 1'b0;
`ifdef LOADER_CHKSUM_EN
            sum   <= 8'h00;
`endif
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            err   <= err_nxt;
`ifdef LOADER_CHKSUM_EN
            sum   <= sum_nxt;
`endif
        end
    end

    // p0 -> p1: accepted data byte becomes a one-cycle memory write
    always_ff @(posedge CLK) begin
        if (!R) begin
            vld_p1  <= 1'b0;
            addr_p1 <= 16'h0000;
            data_p1 <= 8'h00;
        end else begin
            vld_p1 <= wr_p0;
            if (wr_p0) begin
                addr_p1 <= ptr;
                data_p1 <= IN_DATA;
            end
        end
    end

    assign MEM_WE   = vld_p1;
    assign MEM_ADDR = addr_p1;
    assign MEM_DATA = data_p1;
    assign CPU_R    = (state != ST_RUN);
    assign ERR      = err;

endmodule

// File: tb/tb_mem_loader.sv
// Directed self-checking bench for mem_loader; captured MEM_WE writes are compared against hand-computed vectors.
// Follows LOADER_CHKSUM_EN the same way as the design (appends checksum bytes when defined).
module tb_mem_loader;

    logic        CLK = 1'b0;
    logic        R = 1'b0;
    logic [7:0]  IN_DATA = 8'h00;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic        MEM_WE;
    logic [15:0] MEM_ADDR;
    logic [7:0]  MEM_DATA;
    logic        CPU_R;
    logic        ERR;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] cap_addr[$];
    logic [7:0]  cap_data[$];
    logic [7:0]  payload[256];

    mem_loader dut (
        .CLK(CLK), .R(R), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .CPU_R(CPU_R), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // Write monitor samples mid-cycle, so a one-cycle strobe is captured exactly once
    always @(negedge CLK) begin
        if (MEM_WE === 1'b1) begin
            cap_addr.push_back(MEM_ADDR);
            cap_data.push_back(MEM_DATA);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        IN_DATA  = b;
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        IN_DATA  = 8'hEE;
        if (gap) begin
            tick();
            tick();
        end
    endtask

    // LOAD frame for payload[0..n-1]; chk_ok=0 sends a checksum byte of 00 instead of the correct one
    task automatic send_load(input logic [15:0] a, input int n, input bit gap, input bit chk_ok);
        logic [7:0] s;
        logic [7:0] len;
        len = n[7:0];
        s = a[7:0] + a[15:8] + len;
        send_byte(8'hA5, gap);
        send_byte(8'h01, gap);
        send_byte(a[7:0], gap);
        send_byte(a[15:8], gap);
        send_byte(len, gap);
        for (int i = 0; i < n; i++) begin
            s = s + payload[i];
            send_byte(payload[i], gap);
        end
`ifdef LOADER_CHKSUM_EN
        send_byte(chk_ok ? (8'h00 - s) : 8'h00, gap);
`else
        if (!chk_ok) s = 8'h00;
`endif
        tick();
    endtask

    task automatic test_reset();
        R = 1'b0;
        tick();
        tick();
        n_checks++;
        if (MEM_WE !== 1'b0 || MEM_ADDR !== 16'h0000 || MEM_DATA !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mem: we=%b addr=%h data=%h, required 0/0000/00", MEM_WE, MEM_ADDR, MEM_DATA);
        end
        n_checks++;
        if (CPU_R !== 1'b1 || ERR !== 1'b0 || IN_READY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: cpu_r=%b err=%b rdy=%b, required 1/0/0", CPU_R, ERR, IN_READY);
        end
        R = 1'b1;
        tick();
        n_checks++;
        if (IN_READY !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b, required 1", IN_READY);
        end
    endtask

    task automatic test_basic_load();
        cap_addr.delete();
        cap_data.delete();
        payload[0] = 8'h11;
        payload[1] = 8'h22;
        payload[2] = 8'h33;
        send_load(16'h0200, 3, 1'b1, 1'b1);
        n_checks++;
        if (cap_addr.size() != 3) begin
            n_fail++;
            $display("FAIL basic_count: got %0d writes, required 3", cap_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (cap_addr[i] !== 16'(16'h0200 + i) || cap_data[i] !== payload[i]) begin
                    n_fail++;
                    $display("FAIL basic_write%0d: got %h@%h, required %h@%h", i, cap_data[i], cap_addr[i],
                             payload[i], 16'(16'h0200 + i));
                end
            end
        end
        n_checks++;
        if (ERR !== 1'b0 || CPU_R !== 1'b1 || MEM_WE !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_flags: err=%b cpu_r=%b we=%b, required 0/1/0", ERR, CPU_R, MEM_WE);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_a[4];
        exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        cap_addr.delete();
        cap_data.delete();
        payload[0] = 8'hC0;
        payload[1] = 8'hC1;
        payload[2] = 8'hC2;
        payload[3] = 8'hC3;
        send_load(16'hFFFE, 4, 1'b0, 1'b1);
        n_checks++;
        if (cap_addr.size() != 4) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d writes, required 4", cap_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (cap_addr[i] !== exp_a[i] || cap_data[i] !== payload[i]) begin
                    n_fail++;
                    $display("FAIL wrap_write%0d: got %h@%h, required %h@%h", i, cap_data[i], cap_addr[i],
                             payload[i], exp_a[i]);
                end
            end
        end
        n_checks++;
        if (ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_err: got %b, required 0", ERR);
        end
    endtask

    task automatic test_bad_cmd();
        cap_addr.delete();
        cap_data.delete();
        send_byte(8'h3C, 1'b0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h07, 1'b0);
        n_checks++;
        if (ERR !== 1'b1 || cap_addr.size() != 0) begin
            n_fail++;
            $display("FAIL bad_cmd_err: err=%b writes=%0d, required 1/0", ERR, cap_addr.size());
        end
        payload[0] = 8'h5A;
        send_load(16'h1234, 1, 1'b0, 1'b1);
        n_checks++;
        if (cap_addr.size() != 1 || cap_addr[0] !== 16'h1234 || cap_data[0] !== 8'h5A) begin
            n_fail++;
            $display("FAIL bad_cmd_recover: writes=%0d first=%h@%h, required 1 5A@1234",
                     cap_addr.size(), cap_data[0], cap_addr[0]);
        end
        n_checks++;
        if (ERR !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got %b, required 1", ERR);
        end
    endtask

    task automatic test_reset_mid();
        cap_addr.delete();
        cap_data.delete();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        // Third data byte offered in the same cycle reset is asserted
        R        = 1'b0;
        IN_DATA  = 8'h33;
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        n_checks++;
        if (MEM_WE !== 1'b0 || CPU_R !== 1'b1 || ERR !== 1'b0 || MEM_ADDR !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_mid: we=%b cpu_r=%b err=%b addr=%h, required 0/1/0/0000",
                     MEM_WE, CPU_R, ERR, MEM_ADDR);
        end
        R = 1'b1;
        tick();
        send_byte(8'h44, 1'b0);
        tick();
        n_checks++;
        if (cap_addr.size() != 2 || cap_data[0] !== 8'h11 || cap_data[1] !== 8'h22 || cap_addr[1] !== 16'h0201) begin
            n_fail++;
            $display("FAIL reset_mid_writes: count=%0d, required 2 (11@0200, 22@0201)", cap_addr.size());
        end
        cap_addr.delete();
        cap_data.delete();
        payload[0] = 8'h77;
        send_load(16'h0300, 1, 1'b0, 1'b1);
        n_checks++;
        if (cap_addr.size() != 1 || cap_addr[0] !== 16'h0300 || cap_data[0] !== 8'h77) begin
            n_fail++;
            $display("FAIL reset_mid_sync: writes=%0d, required one 77@0300", cap_addr.size());
        end
    endtask

`ifdef LOADER_CHKSUM_EN
    task automatic test_bad_checksum();
        cap_addr.delete();
        cap_data.delete();
        payload[0] = 8'h11;
        payload[1] = 8'h22;
        payload[2] = 8'h33;
        send_load(16'h0200, 3, 1'b0, 1'b0);
        n_checks++;
        if (cap_addr.size() != 3 || ERR !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_checksum: writes=%0d err=%b, required 3/1", cap_addr.size(), ERR);
        end
    endtask
`endif

    task automatic test_full_block_and_run();
        int bad;
        cap_addr.delete();
        cap_data.delete();
        for (int i = 0; i < 256; i++) payload[i] = 8'(i ^ 8'h5C);
        send_load(16'h0200, 256, 1'b0, 1'b1);
        n_checks++;
        if (cap_addr.size() != 256) begin
            n_fail++;
            $display("FAIL block256_count: got %0d writes, required 256", cap_addr.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 256; i++) begin
                if (cap_addr[i] !== 16'(16'h0200 + i) || cap_data[i] !== payload[i]) bad++;
            end
            n_checks++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL block256_data: %0d wrong writes, last=%h@%h, required 0 wrong", bad,
                         cap_data[255], cap_addr[255]);
            end
        end
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        n_checks++;
        if (CPU_R !== 1'b0 || IN_READY !== 1'b0) begin
            n_fail++;
            $display("FAIL run: cpu_r=%b rdy=%b, required 0/0", CPU_R, IN_READY);
        end
        cap_addr.delete();
        cap_data.delete();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        tick();
        n_checks++;
        if (CPU_R !== 1'b0 || IN_READY !== 1'b0 || cap_addr.size() != 0) begin
            n_fail++;
            $display("FAIL run_hold: cpu_r=%b rdy=%b writes=%0d, required 0/0/0", CPU_R, IN_READY, cap_addr.size());
        end
        R = 1'b0;
        tick();
        R = 1'b1;
        tick();
        n_checks++;
        if (CPU_R !== 1'b1 || IN_READY !== 1'b1) begin
            n_fail++;
            $display("FAIL run_exit_reset: cpu_r=%b rdy=%b, required 1/1", CPU_R, IN_READY);
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_wrap();
        test_bad_cmd();
        test_reset_mid();
`ifdef LOADER_CHKSUM_EN
        test_bad_checksum();
`endif
        test_full_block_and_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
